// File: rtl/lod_share_arb.sv
// Round-robin shared leading-one detector: one requester per cycle feeds a
// 2-stage pipeline returning leading-zero count, zero flag and normalized word.
module lod_share_arb #(
  parameter  int N  = 16,
  parameter  int R  = 4,
  localparam int S  = $clog2(N),
  localparam int RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_data,
  output logic [R-1:0]   req_ready,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [S-1:0]   res_lzc,
  output logic           res_zero,
  output logic [N-1:0]   res_norm,
  output logic [RW-1:0]  res_id
);

  function automatic logic [S-1:0] lzc_f(input logic [N-1:0] w);
    logic [S-1:0] c;
    c = '0;
    // Scanning upward lets the highest set bit overwrite lower ones.
    for (int i = 0; i < N; i++) begin
      if (w[i]) c = S'(N - 1 - i);
    end
    return c;
  endfunction

  function automatic logic [N-1:0] norm_f(input logic [N-1:0] w, input logic [S-1:0] sh);
    return w << sh;
  endfunction

  logic [RW-1:0] ptr;
  logic [RW-1:0] ptr_next;
  logic          gnt_found;
  logic [RW-1:0] gnt_id;
  logic [N-1:0]  gnt_data;
  logic          accept;

  logic          vld_p1;
  logic [N-1:0]  data_p1;
  logic [RW-1:0] id_p1;

  logic          vld_p2;
  logic [S-1:0]  lzc_p2;
  logic          zero_p2;
  logic [N-1:0]  norm_p2;
  logic [RW-1:0] id_p2;

  logic          s1_ready;
  logic          s2_ready;

  assign s2_ready = !vld_p2 || res_ready;
  assign s1_ready = !vld_p1 || s2_ready;

  // Arbitration: first valid requester at or after ptr, wrapping modulo R.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_data  = '0;
    for (int k = 0; k < R; k++) begin
      idx = (int'(ptr) + k) % R;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = RW'(idx);
        gnt_data  = req_data[idx*N +: N];
      end
    end
  end

  assign ptr_next = RW'((int'(gnt_id) + 1) % R);
  assign accept   = !rst && gnt_found && s1_ready;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_id] = 1'b1;
  end

  // Control state and result registers; in-flight items are dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      lzc_p2  <= '0;
      zero_p2 <= 1'b0;
      norm_p2 <= '0;
      id_p2   <= '0;
    end else begin
      if (accept)   ptr    <= ptr_next;
      if (s1_ready) vld_p1 <= accept;
      if (s2_ready) vld_p2 <= vld_p1;
      // Stage 1 -> stage 2: detect and normalize the captured word.
      if (vld_p1 && s2_ready) begin
        lzc_p2  <= lzc_f(data_p1);
        zero_p2 <= ~|data_p1;
        norm_p2 <= norm_f(data_p1, lzc_f(data_p1));
        id_p2   <= id_p1;
      end
    end
  end

  // Arbiter -> stage 1: capture the granted word and its requester id.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_p1 <= gnt_data;
      id_p1   <= gnt_id;
    end
  end

  assign res_valid = vld_p2;
  assign res_lzc   = lzc_p2;
  assign res_zero  = zero_p2;
  assign res_norm  = norm_p2;
  assign res_id    = id_p2;

endmodule
